// File: rtl/fp_addsub_sched.sv
`default_nettype none
// =====================================================================
// fp_addsub_sched : round-robin, credit-based scheduler that shares one
// fixed-latency FP add/sub unit between P_NREQ requesters.   Rev 1.0
// =====================================================================
module fp_addsub_sched #(
   parameter int P_EXP   = 5,
   parameter int P_FRAC  = 10,
   parameter int P_WORD  = 1 + P_FRAC + P_EXP,
   parameter int P_NREQ  = 4,
   parameter int P_LAT   = 2,
   parameter int P_DEPTH = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [P_NREQ-1:0]        req_valid,
   output logic [P_NREQ-1:0]        req_ready,
   input  logic [P_NREQ-1:0]        req_op,
   input  logic [3*P_NREQ-1:0]      req_rnd,
   input  logic [P_WORD*P_NREQ-1:0] req_a,
   input  logic [P_WORD*P_NREQ-1:0] req_b,
   output logic                     u_valid,
   output logic                     u_op,
   output logic [2:0]               u_rnd,
   output logic [P_WORD-1:0]        u_a,
   output logic [P_WORD-1:0]        u_b,
   input  logic [P_WORD-1:0]        u_z,
   input  logic [7:0]               u_status,
   output logic [P_NREQ-1:0]        rsp_valid,
   input  logic [P_NREQ-1:0]        rsp_ready,
   output logic [P_WORD-1:0]        rsp_z,
   output logic [7:0]               rsp_status,
   output logic                     busy
);

   localparam int TAG_W = $clog2(P_NREQ);
   localparam int PTR_W = $clog2(P_DEPTH);
   localparam int CNT_W = $clog2(P_DEPTH + 1);
   localparam int OCC_W = $clog2(P_DEPTH + P_LAT + 2);

   logic [TAG_W-1:0]  rr_q, rr_d;
   logic              u_valid_q, u_valid_d;
   logic              u_op_q, u_op_d;
   logic [2:0]        u_rnd_q, u_rnd_d;
   logic [P_WORD-1:0] u_a_q, u_a_d, u_b_q, u_b_d;
   logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic [P_WORD-1:0] rsp_z_q, rsp_z_d;
   logic [7:0]        rsp_status_q, rsp_status_d;

   logic [TAG_W-1:0]  mem_tag_q [P_DEPTH];
   logic [P_WORD-1:0] mem_z_q   [P_DEPTH];
   logic [7:0]        mem_st_q  [P_DEPTH];

   logic              al_vld;
   logic [TAG_W-1:0]  al_tag;
   logic [OCC_W-1:0]  pipe_cnt;
   logic [OCC_W-1:0]  occ;
   logic              credit;
   logic [P_NREQ-1:0] grant;
   logic [TAG_W-1:0]  gnt_tag;
   logic              accept;
   logic              push, pop, load, fifo_full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(P_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Every accepted operation holds one credit until its response is popped.
   assign occ    = OCC_W'(u_valid_q) + pipe_cnt + OCC_W'(mem_cnt_q) + OCC_W'(out_valid_q);
   assign credit = rst_n && (occ < OCC_W'(P_DEPTH));
   assign busy   = (occ != '0);

   always_comb begin
      grant   = '0;
      gnt_tag = '0;
      for (int i = 0; i < P_NREQ; i++) begin
         if (credit && grant == '0 && req_valid[i] && TAG_W'(i) > rr_q) begin
            grant[i] = 1'b1;
            gnt_tag  = TAG_W'(i);
         end
      end
      for (int i = 0; i < P_NREQ; i++) begin
         if (credit && grant == '0 && req_valid[i]) begin
            grant[i] = 1'b1;
            gnt_tag  = TAG_W'(i);
         end
      end
   end

   assign req_ready = grant;
   assign accept    = (grant != '0);

   always_comb begin
      rr_d      = accept ? gnt_tag : rr_q;
      u_valid_d = accept;
      u_op_d    = u_op_q;
      u_rnd_d   = u_rnd_q;
      u_a_d     = u_a_q;
      u_b_d     = u_b_q;
      iss_tag_d = accept ? gnt_tag : iss_tag_q;
      for (int i = 0; i < P_NREQ; i++) begin
         if (grant[i]) begin
            u_op_d  = req_op[i];
            u_rnd_d = req_rnd[3*i +: 3];
            u_a_d   = req_a[P_WORD*i +: P_WORD];
            u_b_d   = req_b[P_WORD*i +: P_WORD];
         end
      end
   end

   generate
      if (P_LAT == 0) begin : g_lat0
         assign al_vld   = u_valid_q;
         assign al_tag   = iss_tag_q;
         assign pipe_cnt = '0;
      end else begin : g_pipe
         logic [P_LAT-1:0]            vld_q, vld_d;
         logic [P_LAT-1:0][TAG_W-1:0] tag_q, tag_d;
         logic [OCC_W-1:0]            cnt;

         always_comb begin
            vld_d[0] = u_valid_q;
            tag_d[0] = iss_tag_q;
            for (int k = 1; k < P_LAT; k++) begin
               vld_d[k] = vld_q[k-1];
               tag_d[k] = tag_q[k-1];
            end
            cnt = '0;
            for (int k = 0; k < P_LAT; k++) begin
               cnt = cnt + OCC_W'(vld_q[k]);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
               tag_q <= '0;
            end else begin
               vld_q <= vld_d;
               tag_q <= tag_d;
            end
         end

         assign al_vld   = vld_q[P_LAT-1];
         assign al_tag   = tag_q[P_LAT-1];
         assign pipe_cnt = cnt;
      end
   endgenerate

   // Head entry lives in a registered output stage, refilled on the pop edge.
   assign push      = al_vld;
   assign pop       = out_valid_q && rsp_ready[out_tag_q];
   assign load      = (mem_cnt_q != '0) && (!out_valid_q || pop);
   assign fifo_full = (OCC_W'(mem_cnt_q) + OCC_W'(out_valid_q)) >= OCC_W'(P_DEPTH);

   always_comb begin
      wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      mem_cnt_d    = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
      out_valid_d  = out_valid_q;
      out_tag_d    = out_tag_q;
      rsp_z_d      = rsp_z_q;
      rsp_status_d = rsp_status_q;
      if (load) begin
         out_valid_d  = 1'b1;
         out_tag_d    = mem_tag_q[rd_ptr_q];
         rsp_z_d      = mem_z_q[rd_ptr_q];
         rsp_status_d = mem_st_q[rd_ptr_q];
      end else if (pop) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_tag_q[wr_ptr_q] <= al_tag;
         mem_z_q[wr_ptr_q]   <= u_z;
         mem_st_q[wr_ptr_q]  <= u_status;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q         <= TAG_W'(P_NREQ - 1);
         u_valid_q    <= 1'b0;
         u_op_q       <= 1'b0;
         u_rnd_q      <= '0;
         u_a_q        <= '0;
         u_b_q        <= '0;
         iss_tag_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_tag_q    <= '0;
         rsp_z_q      <= '0;
         rsp_status_q <= '0;
      end else begin
         rr_q         <= rr_d;
         u_valid_q    <= u_valid_d;
         u_op_q       <= u_op_d;
         u_rnd_q      <= u_rnd_d;
         u_a_q        <= u_a_d;
         u_b_q        <= u_b_d;
         iss_tag_q    <= iss_tag_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_cnt_q    <= mem_cnt_d;
         out_valid_q  <= out_valid_d;
         out_tag_q    <= out_tag_d;
         rsp_z_q      <= rsp_z_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (out_valid_q) rsp_valid[out_tag_q] = 1'b1;
   end

   assign u_valid    = u_valid_q;
   assign u_op       = u_op_q;
   assign u_rnd      = u_rnd_q;
   assign u_a        = u_a_q;
   assign u_b        = u_b_q;
   assign rsp_z      = rsp_z_q;
   assign rsp_status = rsp_status_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_sched.sv
`default_nettype none
// =====================================================================
// tb_fp_addsub_sched : randomized bench with a transaction-level model
// of arbitration, credits and in-order responses.            Rev 1.0
// =====================================================================
module tb_fp_addsub_sched;

   localparam int NREQ  = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 6;
   localparam int W     = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid, req_ready, req_op;
   logic [3*NREQ-1:0] req_rnd;
   logic [W*NREQ-1:0] req_a, req_b;
   logic              u_valid, u_op;
   logic [2:0]        u_rnd;
   logic [W-1:0]      u_a, u_b, u_z, rsp_z;
   logic [7:0]        u_status, rsp_status;
   logic [NREQ-1:0]   rsp_valid, rsp_ready;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dut_acc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_addsub_sched #(
      .P_EXP(5), .P_FRAC(10), .P_WORD(W), .P_NREQ(NREQ), .P_LAT(LAT), .P_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rnd(req_rnd),
      .req_a(req_a), .req_b(req_b),
      .u_valid(u_valid), .u_op(u_op), .u_rnd(u_rnd), .u_a(u_a), .u_b(u_b),
      .u_z(u_z), .u_status(u_status),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_status(rsp_status),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- half-precision arithmetic of the shared unit ----------------
   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
      else        for (int k = 0; k < -n; k++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp_val(input logic [15:0] x);
      int  e = int'(x[14:10]);
      int  f = int'(x[9:0]);
      real m;
      if (e == 0) m = f * pow2(-24);
      else        m = (1024 + f) * pow2(e - 25);
      return x[15] ? -m : m;
   endfunction

   function automatic logic [15:0] fp_enc(input real r);
      logic s = (r < 0.0);
      real  m = s ? -r : r;
      int   e = 0;
      int   fi, be;
      if (m == 0.0) return {s, 15'b0};
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      fi = $rtoi((m - 1.0) * 1024.0 + 0.5);
      if (fi == 1024) begin fi = 0; e++; end
      be = e + 15;
      if (be <= 0)  return {s, 15'b0};
      if (be >= 31) return {s, 5'h1f, 10'b0};
      return {s, be[4:0], fi[9:0]};
   endfunction

   function automatic logic [15:0] unit_z(input logic [15:0] a, input logic [15:0] b, input logic op);
      return fp_enc(op ? fp_val(a) - fp_val(b) : fp_val(a) + fp_val(b));
   endfunction

   function automatic logic [7:0] unit_st(input logic [15:0] a, input logic [15:0] b,
                                          input logic op, input logic [2:0] rnd);
      return {1'b0, op, rnd, a[2:0] ^ b[2:0]};
   endfunction

   logic [23:0] unit_now;
   logic [23:0] unit_sh [1:LAT];
   assign unit_now = {unit_z(u_a, u_b, u_op), unit_st(u_a, u_b, u_op, u_rnd)};
   always @(posedge clk) begin
      for (int k = LAT; k >= 1; k--) unit_sh[k] <= (k == 1) ? unit_now : unit_sh[k-1];
   end
   assign {u_z, u_status} = unit_sh[LAT];

   // ---------------- reference model: queue of outstanding operations ----------------
   typedef struct {
      int          tag;
      logic [15:0] z;
      logic [7:0]  st;
      int          rdy;
   } ent_t;

   ent_t        q[$];
   int          rr;
   bit          prev_acc;
   logic [15:0] last_a, last_b;
   logic [3:0]  last_oprnd;

   always @(negedge clk) begin : mon
      int         g;
      logic [3:0] eg, erv;
      ent_t       e;
      if (!rst_n) begin
         q.delete();
         rr         = NREQ - 1;
         prev_acc   = 1'b0;
         last_a     = '0;
         last_b     = '0;
         last_oprnd = '0;
      end else begin
         g = -1;
         if (q.size() < DEPTH)
            for (int k = 1; k <= NREQ; k++)
               if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
         eg = '0;
         if (g >= 0) eg[g] = 1'b1;
         check("req_ready", req_ready, eg);
         check("busy", busy, q.size() != 0);
         check("u_valid", u_valid, prev_acc);
         check("u_a", u_a, last_a);
         check("u_b", u_b, last_b);
         check("u_op_rnd", {u_op, u_rnd}, last_oprnd);
         erv = '0;
         if (q.size() > 0 && q[0].rdy <= cyc) erv[q[0].tag] = 1'b1;
         check("rsp_valid", rsp_valid, erv);
         if (erv != '0) begin
            check("rsp_z", rsp_z, q[0].z);
            check("rsp_status", rsp_status, q[0].st);
         end
         if ((req_valid & req_ready) != '0) dut_acc++;
         if (erv != '0 && rsp_ready[q[0].tag]) void'(q.pop_front());
         prev_acc = (g >= 0);
         if (g >= 0) begin
            rr         = g;
            last_a     = req_a[W*g +: W];
            last_b     = req_b[W*g +: W];
            last_oprnd = {req_op[g], req_rnd[3*g +: 3]};
            e.tag = g;
            e.z   = unit_z(last_a, last_b, req_op[g]);
            e.st  = unit_st(last_a, last_b, req_op[g], req_rnd[3*g +: 3]);
            e.rdy = cyc + 1 + LAT + 2;
            q.push_back(e);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_fp();
      int s = $urandom_range(0, 1);
      int e = $urandom_range(10, 20);
      int f = $urandom_range(0, 1023);
      return {s[0], e[4:0], f[9:0]};
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[W*i +: W]   = rand_fp();
         req_b[W*i +: W]   = rand_fp();
         req_op[i]         = $urandom_range(0, 1);
         req_rnd[3*i +: 3] = 3'($urandom_range(0, 4));
      end
   endtask

   task automatic drain();
      int n = 0;
      req_valid = '0;
      rsp_ready = '1;
      while (busy !== 1'b0 && n < 100) begin step(); n++; end
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, '0);
      check({tag, "_u"}, {u_valid, u_op, u_rnd, u_a, u_b}, '0);
      check({tag, "_rsp"}, {rsp_valid, rsp_status, rsp_z}, '0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      req_valid = '0; req_op = '0; req_rnd = '0; req_a = '0; req_b = '0;
      rsp_ready = '1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      req_valid = '1;
      repeat (3) step();
      check_reset_outputs("reset");
      req_valid = '0;
      rst_n = 1'b1;

      // single request from requester 2: 1.0 + 2.0
      step();
      req_valid = 4'b0100;
      req_a[W*2 +: W] = 16'h3C00;
      req_b[W*2 +: W] = 16'h4000;
      req_op[2] = 1'b0;
      req_rnd[6 +: 3] = 3'd0;
      step();
      req_valid = '0;
      check("single_u_valid", u_valid, 1'b1);
      repeat (3) step();
      @(negedge clk);
      check("single_early", rsp_valid, 4'b0000);
      step();
      @(negedge clk);
      check("single_rsp_valid", rsp_valid, 4'b0100);
      check("single_rsp_z", rsp_z, 16'h4200);
      drain();

      // all requesters streaming, responses accepted at once
      req_valid = '1;
      repeat (40) begin rand_ops(); step(); end
      drain();

      // responses stalled: credits limit the stream to DEPTH accepts
      begin : stall
         int a0;
         rsp_ready = '0;
         a0 = dut_acc;
         req_valid = 4'b0001;
         repeat (15) begin rand_ops(); step(); end
         check("stall_accepts", dut_acc - a0, DEPTH);
         check("stall_busy", busy, 1'b1);
         rsp_ready = '1;
         repeat (20) begin rand_ops(); step(); end
         drain();
      end

      // head-of-line: tag 1 blocks tag 3
      rsp_ready = 4'b1101;
      req_valid = 4'b0010; rand_ops(); step();
      req_valid = 4'b1000; step();
      req_valid = '0;
      repeat (10) step();
      @(negedge clk);
      check("hol_rsp_valid", rsp_valid, 4'b0010);
      drain();

      // random traffic
      repeat (300) begin
         req_valid = 4'($urandom);
         rsp_ready = 4'($urandom);
         rand_ops();
         step();
      end
      drain();

      // reset with work in flight and results buffered
      rsp_ready = '0;
      req_valid = '1;
      repeat (5) begin rand_ops(); step(); end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      step();
      rst_n = 1'b1;
      rsp_ready = '1;
      @(negedge clk);
      check("post_reset_grant", req_ready, 4'b0001);
      check("post_reset_busy", busy, 1'b0);
      check("post_reset_rsp", rsp_valid, 4'b0000);
      repeat (20) begin rand_ops(); step(); end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
